vector_result_buffer: RTL



---
 rtl/vector_result_buffer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vector_result_buffer.sv
// vector_result_buffer
//   Packs LANES consecutive accumulator results into one vector and queues
//   whole vectors in a DEPTH-entry FIFO drained by a valid/ready handshake.
//
//   Optional feature macro: RESULT_SATURATE_EN
//     defined   -> results are clamped to the signed DATA_W range
//     undefined -> the low DATA_W bits of each result are kept (wrap)
//
//   Ports
//     clk, reset           rising-edge clock, async active-high reset
//     in_valid, in_data    one-cycle strobe with a signed ACC_W result
//     in_flush             drop the partially assembled vector
//     out_valid/out_ready  head-of-FIFO handshake
//     out_data             head vector, lane 0 at LSBs (0 when empty)
//     lane_idx             lane the next in_valid sample fills
//     count                vectors currently queued
//     overflow, drop_cnt   sticky drop flag and saturating drop counter
//     clr_ovf              clears overflow and drop_cnt
module vector_result_buffer #(
    parameter int ACC_W  = 20,
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [ACC_W-1:0]              in_data,
    input  logic                          in_flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_W-1:0]       out_data,
    output logic [$clog2(LANES)-1:0]      lane_idx,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt,
    input  logic                          clr_ovf
);
    localparam int LW = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [LW-1:0]                  lane_idx_q, lane_idx_d;
    logic [LANES-1:0][DATA_W-1:0]   asm_q, asm_d;
    logic [LANES-1:0][DATA_W-1:0]   push_vec;
    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]                  count_q, count_d;
    logic                           overflow_q, overflow_d;
    logic [7:0]                     drop_cnt_q, drop_cnt_d;
    logic [LANES*DATA_W-1:0]        mem_q [DEPTH];

    logic [DATA_W-1:0] conv;
    logic complete, pop, full, push_ok, drop;

    // ACC_W -> DATA_W conversion of the incoming sample
`ifdef RESULT_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        conv = DATA_W'(in_data);
        if ($signed(in_data) > SAT_MAX)      conv = DATA_W'(SAT_MAX);
        else if ($signed(in_data) < SAT_MIN) conv = DATA_W'(SAT_MIN);
    end
`else
    always_comb begin
        conv = DATA_W'(in_data);
    end
`endif

    // Completed vector = assembly contents with the final lane merged in
    always_comb begin
        push_vec             = asm_q;
        push_vec[lane_idx_q] = conv;
    end

    // Full when the wrap bits differ and the index bits match
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = out_valid && out_ready;
    assign complete = in_valid && !in_flush && (lane_idx_q == LW'(LANES-1));
    // A pop in the same cycle frees the slot the push needs
    assign push_ok  = complete && (!full || pop);
    assign drop     = complete && full && !pop;

    always_comb begin
        lane_idx_d = lane_idx_q;
        asm_d      = asm_q;
        if (in_flush) begin
            lane_idx_d = '0;
            asm_d      = '0;
        end else if (in_valid) begin
            if (complete) begin
                lane_idx_d = '0;
                asm_d      = '0;
            end else begin
                asm_d[lane_idx_q] = conv;
                lane_idx_d        = lane_idx_q + LW'(1);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + PW'(push_ok) - PW'(pop);
    end

    // A drop in the same cycle as clr_ovf restarts the count at 1
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf)                  drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_idx_q <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            lane_idx_q <= lane_idx_d;
            asm_q      <= asm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: out_data is masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_vec;
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign lane_idx  = lane_idx_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
